// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: constants, divider state encoding, unpacked operand.
// FP16_DIV_SUBNORMAL_EN selects subnormal support (NORM state, gradual underflow).
package fp16_pkg;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam int          FP16_BIAS    = 15;
    localparam int          FP16_EXP_MAX = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef FP16_DIV_SUBNORMAL_EN
        ST_NORM  = 3'd1,
`endif
        ST_DIV   = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [10:0] sig;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp16_op_t;

    // A subnormal exponent field is reported as 1 so exponent arithmetic stays uniform.
    function automatic fp16_op_t fp16_unpack(input logic [15:0] x);
        fp16_op_t u;
        u.sign   = x[15];
        u.exp    = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        u.sig    = {x[14:10] != 5'd0, x[9:0]};
        u.is_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
        u.is_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
`ifdef FP16_DIV_SUBNORMAL_EN
        u.is_zero = (x[14:0] == 15'd0);
`else
        u.is_zero = (x[14:10] == 5'd0);
`endif
        return u;
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational RNE rounding, overflow, denormalization and packing of an FP16 result.
// Denormalization exists only with FP16_DIV_SUBNORMAL_EN; otherwise e <= 0 flushes to zero.
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [7:0] i_exp,
    input  logic [10:0]       i_sig,
    input  logic              i_guard,
    input  logic              i_sticky,
    output logic [15:0]       o_result
);

    localparam logic signed [7:0] EXP_MAX = 8'(FP16_EXP_MAX);

    logic [10:0]       w_sig;
    logic              w_guard;
    logic              w_sticky;
    logic              w_denorm;
    logic              w_rnd;
    logic [11:0]       w_sum;
    logic [10:0]       w_sig_r;
    logic signed [7:0] w_exp;
`ifdef FP16_DIV_SUBNORMAL_EN
    logic signed [7:0] w_shift_raw;
    logic [3:0]        w_shift;
    logic [23:0]       w_ext;
`endif

    always_comb begin
        w_sig    = i_sig;
        w_guard  = i_guard;
        w_sticky = i_sticky;
        w_denorm = 1'b0;
`ifdef FP16_DIV_SUBNORMAL_EN
        w_shift_raw = 8'sd1 - i_exp;
        w_shift     = (w_shift_raw > 8'sd12) ? 4'd12 : w_shift_raw[3:0];
        // Guard rides along below sig; everything below the new guard feeds sticky.
        w_ext       = {i_sig, i_guard, 12'd0} >> w_shift;
        if (i_exp <= 8'sd0) begin
            w_sig    = w_ext[23:13];
            w_guard  = w_ext[12];
            w_sticky = i_sticky | (|w_ext[11:0]);
            w_denorm = 1'b1;
        end
`endif
        w_rnd   = w_guard & (w_sticky | w_sig[0]);
        w_sum   = {1'b0, w_sig} + {11'd0, w_rnd};
        w_sig_r = w_sum[10:0];
        w_exp   = i_exp;
        if (w_sum[11]) begin
            w_sig_r = 11'h400;
            w_exp   = i_exp + 8'sd1;
        end
        // A denormal that rounds up into bit 10 naturally encodes exponent field 1.
        if (w_denorm)
            o_result = {i_sign, 4'd0, w_sig_r};
        else if (w_exp >= EXP_MAX)
            o_result = {i_sign, 5'h1F, 10'd0};
        else if (w_exp <= 8'sd0)
            o_result = {i_sign, 15'd0};
        else
            o_result = {i_sign, w_exp[4:0], w_sig_r[9:0]};
    end

endmodule

// File: rtl/fp16_divider.sv
// Iterative FP16 divider (restoring, one quotient bit per cycle) with valid/ready on both sides.
// FP16_DIV_SUBNORMAL_EN adds the NORM state that normalizes subnormal operands.
module fp16_divider
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        div_by_zero
);

    localparam logic signed [7:0] BIAS = 8'(FP16_BIAS);

    state_t            r_state;
    logic              r_sign;
    logic signed [7:0] r_exp;
`ifdef FP16_DIV_SUBNORMAL_EN
    logic [10:0]       r_ma;
`endif
    logic [10:0]       r_mb;
    logic [12:0]       r_rem;
    logic [12:0]       r_quo;
    logic [3:0]        r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [15:0]       r_result;
    logic              r_dbz;

    fp16_op_t          w_ua;
    fp16_op_t          w_ub;
    logic              w_sign;
    logic signed [7:0] w_exp_diff;
    logic              w_special;
    logic [15:0]       w_spec_res;
    logic              w_spec_dbz;
    logic              w_ge;
    logic [12:0]       w_rem_sub;
    logic signed [7:0] w_rp_exp;
    logic [10:0]       w_rp_sig;
    logic              w_rp_guard;
    logic              w_rp_sticky;
    logic [15:0]       w_packed;

    assign w_ua       = fp16_unpack(a);
    assign w_ub       = fp16_unpack(b);
    assign w_sign     = w_ua.sign ^ w_ub.sign;
    assign w_exp_diff = $signed({3'd0, w_ua.exp}) - $signed({3'd0, w_ub.exp}) + BIAS;

    // Priority matters: inf/0 is an infinite result, not a divide-by-zero.
    always_comb begin
        w_special  = 1'b1;
        w_spec_dbz = 1'b0;
        w_spec_res = FP16_QNAN;
        if (w_ua.is_nan || w_ub.is_nan || (w_ua.is_inf && w_ub.is_inf) ||
            (w_ua.is_zero && w_ub.is_zero))
            w_spec_res = FP16_QNAN;
        else if (w_ua.is_inf)
            w_spec_res = {w_sign, 5'h1F, 10'd0};
        else if (w_ub.is_zero) begin
            w_spec_res = {w_sign, 5'h1F, 10'd0};
            w_spec_dbz = 1'b1;
        end else if (w_ua.is_zero || w_ub.is_inf)
            w_spec_res = {w_sign, 15'd0};
        else
            w_special = 1'b0;
    end

    assign w_ge      = (r_rem >= {2'd0, r_mb});
    assign w_rem_sub = w_ge ? (r_rem - {2'd0, r_mb}) : r_rem;

    // q is the quotient scaled by 2^12; a clear top bit means the quotient is below 1.
    assign w_rp_sig    = r_quo[12] ? r_quo[12:2] : r_quo[11:1];
    assign w_rp_guard  = r_quo[12] ? r_quo[1] : r_quo[0];
    assign w_rp_sticky = (r_quo[12] & r_quo[0]) | (r_rem != 13'd0);
    assign w_rp_exp    = r_quo[12] ? r_exp : (r_exp - 8'sd1);

    fp16_round_pack u_round_pack (
        .i_sign   (r_sign),
        .i_exp    (w_rp_exp),
        .i_sig    (w_rp_sig),
        .i_guard  (w_rp_guard),
        .i_sticky (w_rp_sticky),
        .o_result (w_packed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 8'sd0;
`ifdef FP16_DIV_SUBNORMAL_EN
            r_ma        <= 11'd0;
`endif
            r_mb        <= 11'd0;
            r_rem       <= 13'd0;
            r_quo       <= 13'd0;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 16'd0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= w_sign;
                        r_exp      <= w_exp_diff;
`ifdef FP16_DIV_SUBNORMAL_EN
                        r_ma       <= w_ua.sig;
`endif
                        r_mb       <= w_ub.sig;
                        r_rem      <= {2'd0, w_ua.sig};
                        r_quo      <= 13'd0;
                        r_cnt      <= 4'd0;
                        if (w_special) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_spec_res;
                            r_dbz       <= w_spec_dbz;
`ifdef FP16_DIV_SUBNORMAL_EN
                        end else if (!w_ua.sig[10] || !w_ub.sig[10]) begin
                            r_state <= ST_NORM;
`endif
                        end else begin
                            r_state <= ST_DIV;
                        end
                    end
                end
`ifdef FP16_DIV_SUBNORMAL_EN
                // Dividend first, then divisor; leave on the step that sets the last bit 10.
                ST_NORM: begin
                    if (!r_ma[10]) begin
                        r_ma  <= {r_ma[9:0], 1'b0};
                        r_rem <= {1'b0, r_ma, 1'b0};
                        r_exp <= r_exp - 8'sd1;
                        if (r_ma[9] && r_mb[10])
                            r_state <= ST_DIV;
                    end else begin
                        r_mb  <= {r_mb[9:0], 1'b0};
                        r_exp <= r_exp + 8'sd1;
                        if (r_mb[9])
                            r_state <= ST_DIV;
                    end
                end
`endif
                ST_DIV: begin
                    r_quo <= {r_quo[11:0], w_ge};
                    r_rem <= {w_rem_sub[11:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd12)
                        r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_result    <= w_packed;
                    r_dbz       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign div_by_zero = r_dbz;

endmodule
